rv_hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage RV core. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use, taken branch/jump, multi-cycle MUL/DIV occupancy in EX, and data-memory wait states. It drives per-stage stall (hold) and flush (insert NOP) controls for the pipeline registers and sequences the MUL/DIV unit start handshake. It also keeps a saturating stall-cycle performance counter.

---
 rtl/rv_hazard_ctrl_pkg.sv | 15 +
 rtl/rv_hazard_ctrl_stall_counter.sv | 29 ++
 rtl/rv_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_rv_hazard_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_hazard_ctrl_pkg.sv
// rv_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   md_state_t - MUL/DIV sequencing FSM state (IDLE, MD_BUSY, MD_HOLD)
//   REG_X0     - index of the hard-wired zero register
package rv_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_HOLD = 2'd2
  } md_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/rv_hazard_ctrl_stall_counter.sv
// rv_stall_counter
// Saturating up-counter with enable, used for the stall-cycle statistic.
// Ports:
//   clk_i   - clock
//   rst_i   - synchronous active-high reset, clears the count
//   en_i    - count this cycle
//   count_o - current count, sticks at all-ones
module rv_stall_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ALL_ONE = {CNT_W{1'b1}};

  // Stop at all-ones so a long run never wraps back to a small value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (en_i && (count_o != ALL_ONE)) begin
      count_o <= count_o + ONE;
    end
  end

endmodule

// File: rtl/rv_hazard_ctrl.sv
// rv_hazard_ctrl
// Hazard and stall controller for the 5-stage core. Resolves what the
// forwarding unit cannot: data-memory wait states, multi-cycle MUL/DIV in EX,
// taken branches and load-use. Drives per-stage hold/NOP controls, sequences
// the MUL/DIV start handshake and counts front-end stall cycles.
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   ID_rs1_i/ID_rs2_i            - source registers of the ID instruction
//   ID_use_rs1_i/ID_use_rs2_i    - ID instruction really reads that source
//   EX_mem_read_i, EX_rd_i       - EX instruction is a load / its destination
//   EX_md_i                      - EX instruction is MUL/DIV/REM
//   EX_branch_taken_i            - branch/jump resolved taken in EX
//   MEM_req_i, dmem_ready_i      - MEM data access and its completion
//   md_done_i                    - MUL/DIV result valid pulse
//   md_start_o                   - MUL/DIV start pulse
//   stall_*_o                    - hold PC, IF/ID, ID/EX, EX/MEM
//   flush_*_o                    - NOP into IF/ID, ID/EX, EX/MEM, MEM/WB
//   stall_cnt_o                  - saturating count of cycles with stall_IF_o
module rv_hazard_ctrl
  import rv_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_use_rs1_i,
  input  logic             ID_use_rs2_i,
  input  logic             EX_mem_read_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_md_i,
  input  logic             EX_branch_taken_i,
  input  logic             MEM_req_i,
  input  logic             dmem_ready_i,
  input  logic             md_done_i,
  output logic             md_start_o,
  output logic             stall_IF_o,
  output logic             stall_ID_o,
  output logic             stall_EX_o,
  output logic             stall_MEM_o,
  output logic             flush_ID_o,
  output logic             flush_EX_o,
  output logic             flush_MEM_o,
  output logic             flush_WB_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  md_state_t state, state_next;

  logic mem_stall;
  logic md_stall;
  logic load_use;

  assign mem_stall = MEM_req_i & ~dmem_ready_i;

  // MD_HOLD deliberately contributes nothing: the result is already parked
  // in the MUL/DIV unit, only the memory wait keeps the pipe frozen.
  assign md_stall = ((state == IDLE) & EX_md_i) |
                    ((state == MD_BUSY) & ~md_done_i);

  assign load_use = EX_mem_read_i & (EX_rd_i != REG_X0) &
                    (((EX_rd_i == ID_rs1_i) & ID_use_rs1_i) |
                     ((EX_rd_i == ID_rs2_i) & ID_use_rs2_i));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, start pulse and the prioritised stall/flush decode.
  // A memory wait freezes everything including EX, so a MUL/DIV that
  // finishes under it must be parked in MD_HOLD rather than retired.
  always_comb begin
    state_next  = state;
    md_start_o  = 1'b0;
    stall_IF_o  = 1'b0;
    stall_ID_o  = 1'b0;
    stall_EX_o  = 1'b0;
    stall_MEM_o = 1'b0;
    flush_ID_o  = 1'b0;
    flush_EX_o  = 1'b0;
    flush_MEM_o = 1'b0;
    flush_WB_o  = 1'b0;

    case (state)
      IDLE: begin
        if (EX_md_i && !mem_stall) begin
          md_start_o = 1'b1;
          state_next = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (md_done_i) begin
          state_next = mem_stall ? MD_HOLD : IDLE;
        end
      end
      MD_HOLD: begin
        if (!mem_stall) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (mem_stall) begin
      stall_IF_o  = 1'b1;
      stall_ID_o  = 1'b1;
      stall_EX_o  = 1'b1;
      stall_MEM_o = 1'b1;
      flush_WB_o  = 1'b1;
    end else if (md_stall) begin
      stall_IF_o  = 1'b1;
      stall_ID_o  = 1'b1;
      stall_EX_o  = 1'b1;
      flush_MEM_o = 1'b1;
    end else if (EX_branch_taken_i) begin
      // The ID instruction is squashed, so any load-use on it is moot.
      flush_ID_o = 1'b1;
      flush_EX_o = 1'b1;
    end else if (load_use) begin
      stall_IF_o = 1'b1;
      stall_ID_o = 1'b1;
      flush_EX_o = 1'b1;
    end
  end

  rv_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (stall_IF_o),
    .count_o(stall_cnt_o)
  );

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// tb_rv_hazard_ctrl
// Directed bench for rv_hazard_ctrl. A second instance with a 4-bit counter
// shares all inputs so saturation can be reached in a few cycles.
module tb_rv_hazard_ctrl;

  // Output vector order:
  // {md_start, stall_IF, stall_ID, stall_EX, stall_MEM,
  //  flush_ID, flush_EX, flush_MEM, flush_WB}
  localparam logic [8:0] V_NONE = 9'b0_0000_0000;
  localparam logic [8:0] V_LU   = 9'b0_1100_0100;
  localparam logic [8:0] V_MDS  = 9'b1_1110_0010;
  localparam logic [8:0] V_MD   = 9'b0_1110_0010;
  localparam logic [8:0] V_MEM  = 9'b0_1111_0001;
  localparam logic [8:0] V_BR   = 9'b0_0000_1100;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2;
  logic       use_rs1, use_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_md;
  logic       br_taken;
  logic       mem_req;
  logic       dmem_ready;
  logic       md_done;

  logic        md_start, stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, flush_mem, flush_wb;
  logic [31:0] stall_cnt;

  logic        md_start4, stall_if4, stall_id4, stall_ex4, stall_mem4;
  logic        flush_id4, flush_ex4, flush_mem4, flush_wb4;
  logic [3:0]  stall_cnt4;

  logic [8:0]  out_vec, out_vec4, exp_vec;
  logic [31:0] exp_cnt;
  logic [3:0]  exp_cnt4;
  int          checks;
  int          errors;

  assign out_vec  = {md_start, stall_if, stall_id, stall_ex, stall_mem,
                     flush_id, flush_ex, flush_mem, flush_wb};
  assign out_vec4 = {md_start4, stall_if4, stall_id4, stall_ex4, stall_mem4,
                     flush_id4, flush_ex4, flush_mem4, flush_wb4};

  rv_hazard_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2),
    .ID_use_rs1_i(use_rs1), .ID_use_rs2_i(use_rs2),
    .EX_mem_read_i(ex_mem_read), .EX_rd_i(ex_rd), .EX_md_i(ex_md),
    .EX_branch_taken_i(br_taken), .MEM_req_i(mem_req),
    .dmem_ready_i(dmem_ready), .md_done_i(md_done),
    .md_start_o(md_start),
    .stall_IF_o(stall_if), .stall_ID_o(stall_id),
    .stall_EX_o(stall_ex), .stall_MEM_o(stall_mem),
    .flush_ID_o(flush_id), .flush_EX_o(flush_ex),
    .flush_MEM_o(flush_mem), .flush_WB_o(flush_wb),
    .stall_cnt_o(stall_cnt)
  );

  rv_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .ID_rs1_i(id_rs1), .ID_rs2_i(id_rs2),
    .ID_use_rs1_i(use_rs1), .ID_use_rs2_i(use_rs2),
    .EX_mem_read_i(ex_mem_read), .EX_rd_i(ex_rd), .EX_md_i(ex_md),
    .EX_branch_taken_i(br_taken), .MEM_req_i(mem_req),
    .dmem_ready_i(dmem_ready), .md_done_i(md_done),
    .md_start_o(md_start4),
    .stall_IF_o(stall_if4), .stall_ID_o(stall_id4),
    .stall_EX_o(stall_ex4), .stall_MEM_o(stall_mem4),
    .flush_ID_o(flush_id4), .flush_EX_o(flush_ex4),
    .flush_MEM_o(flush_mem4), .flush_WB_o(flush_wb4),
    .stall_cnt_o(stall_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; the counter model follows the expected stall_IF.
  task automatic tick();
    if (rst) begin
      exp_cnt  = '0;
      exp_cnt4 = '0;
    end else if (exp_vec[7]) begin
      exp_cnt = exp_cnt + 32'd1;
      if (exp_cnt4 != 4'hF) exp_cnt4 = exp_cnt4 + 4'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_md = 1'b0; br_taken = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0; md_done = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    exp_vec = V_NONE;
    tick();
    tick();
    rst = 1'b0;
    #2;
    checks++;
    if (out_vec !== V_NONE) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", out_vec, V_NONE);
    end
    checks++;
    if (out_vec4 !== V_NONE) begin
      errors++;
      $display("[TB] FAIL reset_outputs_w4: got %b expected %b", out_vec4, V_NONE);
    end
    checks++;
    if (stall_cnt !== 32'd0 || stall_cnt4 !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_counter: got %0d/%0d expected 0/0", stall_cnt, stall_cnt4);
    end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; use_rs1 = 1'b1; id_rs2 = 5'd7; use_rs2 = 1'b1;
    exp_vec = V_LU;
    #2;
    checks++;
    if (out_vec !== V_LU) begin
      errors++;
      $display("[TB] FAIL load_use_bubble: got %b expected %b", out_vec, V_LU);
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL load_use_cnt_before: got %0d expected 0", stall_cnt);
    end
    tick();
    clear_inputs();
    exp_vec = V_NONE;
    #2;
    checks++;
    if (out_vec !== V_NONE) begin
      errors++;
      $display("[TB] FAIL load_use_release: got %b expected %b", out_vec, V_NONE);
    end
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++;
      $display("[TB] FAIL load_use_cnt_after: got %0d expected 1", stall_cnt);
    end
    tick();
  endtask

  task automatic test_no_false_stall();
    logic [4:0] rd_t  [4] = '{5'd0, 5'd5, 5'd5, 5'd9};
    logic [4:0] rs1_t [4] = '{5'd0, 5'd1, 5'd1, 5'd9};
    logic [4:0] rs2_t [4] = '{5'd3, 5'd5, 5'd5, 5'd2};
    logic       u1_t  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       u2_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [8:0] ex_t  [4] = '{V_NONE, V_NONE, V_LU, V_NONE};
    for (int i = 0; i < 4; i++) begin
      ex_mem_read = 1'b1; ex_rd = rd_t[i];
      id_rs1 = rs1_t[i]; id_rs2 = rs2_t[i];
      use_rs1 = u1_t[i]; use_rs2 = u2_t[i];
      exp_vec = ex_t[i];
      #2;
      checks++;
      if (out_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL load_use_decode case %0d: got %b expected %b", i, out_vec, exp_vec);
      end
      tick();
    end
    clear_inputs();
    exp_vec = V_NONE;
    tick();
  endtask

  task automatic test_mul_back_to_back();
    logic       md_t [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    logic       dn_t [10] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 1};
    logic [8:0] ex_t [10] = '{V_MDS, V_MD, V_MD, V_MD, V_NONE,
                              V_MDS, V_NONE, V_NONE, V_MDS, V_NONE};
    for (int i = 0; i < 10; i++) begin
      ex_md = md_t[i]; md_done = dn_t[i];
      exp_vec = ex_t[i];
      #2;
      checks++;
      if (out_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL mul_seq cycle %0d: got %b expected %b", i, out_vec, exp_vec);
      end
      tick();
    end
    clear_inputs();
    exp_vec = V_NONE;
    tick();
    checks++;
    if (stall_cnt !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL mul_stall_cnt: got %0d expected %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_md_hold();
    logic       md_t [8] = '{1, 1, 1, 1, 1, 0, 1, 1};
    logic       dn_t [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
    logic       rq_t [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
    logic [8:0] ex_t [8] = '{V_MDS, V_MD, V_MEM, V_MEM, V_NONE,
                             V_NONE, V_MDS, V_NONE};
    dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ex_md = md_t[i]; md_done = dn_t[i]; mem_req = rq_t[i];
      exp_vec = ex_t[i];
      #2;
      checks++;
      if (out_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL md_hold cycle %0d: got %b expected %b", i, out_vec, exp_vec);
      end
      tick();
    end
    clear_inputs();
    exp_vec = V_NONE;
    tick();
  endtask

  task automatic test_branch_priority();
    logic       md_t  [5] = '{0, 0, 0, 1, 1};
    logic       dn_t  [5] = '{0, 0, 0, 0, 1};
    logic       rq_t  [5] = '{0, 1, 1, 0, 0};
    logic       rdy_t [5] = '{0, 0, 1, 0, 0};
    logic       br_t  [5] = '{1, 1, 1, 1, 0};
    logic [8:0] ex_t  [5] = '{V_BR, V_MEM, V_BR, V_MDS, V_NONE};
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; use_rs1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ex_md = md_t[i]; md_done = dn_t[i]; mem_req = rq_t[i];
      dmem_ready = rdy_t[i]; br_taken = br_t[i];
      if (i >= 3) ex_mem_read = 1'b0;
      exp_vec = ex_t[i];
      #2;
      checks++;
      if (out_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL branch_prio case %0d: got %b expected %b", i, out_vec, exp_vec);
      end
      tick();
    end
    clear_inputs();
    exp_vec = V_NONE;
    tick();
  endtask

  task automatic test_reset_mid_op();
    ex_md = 1'b1;
    exp_vec = V_MDS;
    #2;
    checks++;
    if (out_vec !== V_MDS) begin
      errors++;
      $display("[TB] FAIL rst_mid_start: got %b expected %b", out_vec, V_MDS);
    end
    tick();
    rst = 1'b1;
    md_done = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    exp_vec = V_NONE;
    #2;
    checks++;
    if (out_vec !== V_NONE || stall_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_clear: got %b cnt %0d expected %b cnt 0", out_vec, stall_cnt, V_NONE);
    end
    tick();
    ex_md = 1'b1;
    exp_vec = V_MDS;
    #2;
    checks++;
    if (out_vec !== V_MDS) begin
      errors++;
      $display("[TB] FAIL rst_mid_restart: got %b expected %b", out_vec, V_MDS);
    end
    tick();
    md_done = 1'b1;
    exp_vec = V_NONE;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    exp_vec = V_NONE;
    tick();
    rst = 1'b0;
    mem_req = 1'b1; dmem_ready = 1'b0;
    exp_vec = V_MEM;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (stall_cnt4 !== 4'd14 || stall_cnt !== 32'd14) begin
      errors++;
      $display("[TB] FAIL sat_count14: got %0d/%0d expected 14/14", stall_cnt4, stall_cnt);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (stall_cnt4 !== 4'd15) begin
      errors++;
      $display("[TB] FAIL sat_hold15: got %0d expected 15", stall_cnt4);
    end
    checks++;
    if (stall_cnt !== exp_cnt || exp_cnt !== 32'd20) begin
      errors++;
      $display("[TB] FAIL sat_wide_count: got %0d expected 20", stall_cnt);
    end
    checks++;
    if (out_vec4 !== V_MEM) begin
      errors++;
      $display("[TB] FAIL sat_outputs_w4: got %b expected %b", out_vec4, V_MEM);
    end
    clear_inputs();
    exp_vec = V_NONE;
    tick();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_cnt  = '0;
    exp_cnt4 = '0;
    exp_vec  = V_NONE;
    rst      = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_mul_back_to_back();
    test_md_hold();
    test_branch_priority();
    test_reset_mid_op();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
